// File: rtl/nv_nvdla_mcif_read_eg_lat_fifo_flop.sv
// Latency FIFO with flop-array storage for the MCIF read egress path.
// Registered occupancy drives both handshakes; reads are combinational from the flops.
module nv_nvdla_mcif_read_eg_lat_fifo_flop #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 512,
   localparam int AW    = (DEPTH > 2) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             nvdla_core_clk,
   input  logic             nvdla_core_rstn,
   input  logic [31:0]      pwrbus_ram_pd,
   input  logic             wr_pvld,
   output logic             wr_prdy,
   input  logic [WIDTH-1:0] wr_pd,
   output logic             rd_pvld,
   input  logic             rd_prdy,
   output logic [WIDTH-1:0] rd_pd,
   output logic [CW-1:0]    wr_count
);

   localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] ram [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             accept;
   logic             pop;
   logic             unused_pwrbus;

   // Explicit wrap so non-power-of-two depths never index past the array.
   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + AW'(1);
   endfunction

   assign unused_pwrbus = ^pwrbus_ram_pd;

   assign wr_prdy  = (count != FULL_CNT);
   assign rd_pvld  = (count != '0);
   assign accept   = wr_pvld & wr_prdy;
   assign pop      = rd_pvld & rd_prdy;
   assign rd_pd    = rd_pvld ? ram[rd_ptr] : '0;
   assign wr_count = count;

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (accept) wr_ptr <= next_ptr(wr_ptr);
         if (pop)    rd_ptr <= next_ptr(rd_ptr);
         unique case ({accept, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Payload storage carries no reset; validity is tracked by count alone.
   always_ff @(posedge nvdla_core_clk) begin
      if (accept) ram[wr_ptr] <= wr_pd;
   end

endmodule

// File: tb/tb_nv_nvdla_mcif_read_eg_lat_fifo_flop.sv
// Bench for the latency FIFO: vector table on a 4x512 instance, queue model on a 5x32 instance.
module tb_nv_nvdla_mcif_read_eg_lat_fifo_flop;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic [31:0]  pwr = 32'h0;

   logic         wv4 = 1'b0, rr4 = 1'b0, wrdy4, rvld4;
   logic [511:0] wd4 = '0, rd4;
   logic [2:0]   cnt4;

   logic         wv5 = 1'b0, rr5 = 1'b0, wrdy5, rvld5;
   logic [31:0]  wd5 = '0, rd5;
   logic [2:0]   cnt5;

   int pass_cnt = 0;
   int total    = 0;

   logic [31:0] q5 [$];
   bit          last_acc5;

   always #5 clk = ~clk;

   nv_nvdla_mcif_read_eg_lat_fifo_flop #(.DEPTH(4), .WIDTH(512)) u_d4 (
      .nvdla_core_clk(clk), .nvdla_core_rstn(rstn), .pwrbus_ram_pd(pwr),
      .wr_pvld(wv4), .wr_prdy(wrdy4), .wr_pd(wd4),
      .rd_pvld(rvld4), .rd_prdy(rr4), .rd_pd(rd4), .wr_count(cnt4));

   nv_nvdla_mcif_read_eg_lat_fifo_flop #(.DEPTH(5), .WIDTH(32)) u_d5 (
      .nvdla_core_clk(clk), .nvdla_core_rstn(rstn), .pwrbus_ram_pd(pwr),
      .wr_pvld(wv5), .wr_prdy(wrdy5), .wr_pd(wd5),
      .rd_pvld(rvld5), .rd_prdy(rr5), .rd_pd(rd5), .wr_count(cnt5));

   function automatic logic [511:0] fill(input logic [7:0] b);
      return {64{b}};
   endfunction

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic check4(input string tag, input logic e_wrdy, input logic e_rvld,
                         input logic [511:0] e_pd, input int e_cnt);
      check({tag, " wr_prdy"},  512'(wrdy4), 512'(e_wrdy));
      check({tag, " rd_pvld"},  512'(rvld4), 512'(e_rvld));
      check({tag, " rd_pd"},    rd4, e_pd);
      check({tag, " wr_count"}, 512'(cnt4), 512'(e_cnt));
   endtask

   task automatic d4_step(input logic wv, input logic [511:0] wd, input logic rr);
      wv4 = wv; wd4 = wd; rr4 = rr;
      @(posedge clk); #1;
   endtask

   // Model step: decide handshakes from the queue, advance one edge, then compare.
   task automatic d5_cycle(input string tag, input logic wv, input logic [31:0] wd, input logic rr);
      bit acc, pp;
      wv5 = wv; wd5 = wd; rr5 = rr;
      acc = wv && (q5.size() != 5);
      pp  = rr && (q5.size() != 0);
      @(posedge clk); #1;
      if (pp)  void'(q5.pop_front());
      if (acc) q5.push_back(wd);
      last_acc5 = acc;
      check({tag, " d5 wr_prdy"},  512'(wrdy5), 512'(q5.size() != 5));
      check({tag, " d5 rd_pvld"},  512'(rvld5), 512'(q5.size() != 0));
      check({tag, " d5 rd_pd"},    512'(rd5), 512'((q5.size() != 0) ? q5[0] : 32'h0));
      check({tag, " d5 wr_count"}, 512'(cnt5), 512'(q5.size()));
   endtask

   typedef struct {
      logic       wv;
      logic [7:0] wb;
      logic       rr;
      logic       e_wrdy;
      logic       e_rvld;
      logic [7:0] e_b;
      int         e_cnt;
   } vec_t;

   vec_t vecs [$];

   initial begin
      logic        hold_v;
      logic [31:0] hold_d;

      // fill, held 5th write, full + simultaneous pop/write, drain
      vecs.push_back('{1, 8'h11, 0, 1, 1, 8'h11, 1});
      vecs.push_back('{1, 8'h22, 0, 1, 1, 8'h11, 2});
      vecs.push_back('{1, 8'h33, 0, 1, 1, 8'h11, 3});
      vecs.push_back('{1, 8'h44, 0, 0, 1, 8'h11, 4});
      vecs.push_back('{1, 8'h55, 0, 0, 1, 8'h11, 4});
      vecs.push_back('{1, 8'h55, 1, 1, 1, 8'h22, 3});
      vecs.push_back('{1, 8'h55, 1, 1, 1, 8'h33, 3});
      vecs.push_back('{0, 8'h00, 1, 1, 1, 8'h44, 2});
      vecs.push_back('{0, 8'h00, 1, 1, 1, 8'h55, 1});
      vecs.push_back('{0, 8'h00, 1, 1, 0, 8'h00, 0});
      vecs.push_back('{0, 8'h00, 1, 1, 0, 8'h00, 0});
      vecs.push_back('{1, 8'h11, 0, 1, 1, 8'h11, 1});
      vecs.push_back('{1, 8'h22, 0, 1, 1, 8'h11, 2});
      vecs.push_back('{1, 8'h33, 0, 1, 1, 8'h11, 3});
      vecs.push_back('{1, 8'h44, 0, 0, 1, 8'h11, 4});
      vecs.push_back('{0, 8'h00, 1, 1, 1, 8'h22, 3});
      vecs.push_back('{0, 8'h00, 1, 1, 1, 8'h33, 2});
      vecs.push_back('{0, 8'h00, 1, 1, 1, 8'h44, 1});
      vecs.push_back('{0, 8'h00, 1, 1, 0, 8'h00, 0});

      #12 rstn = 1'b1;
      #1 check4("reset", 1'b1, 1'b0, '0, 0);

      foreach (vecs[i])
         begin
            d4_step(vecs[i].wv, fill(vecs[i].wb), vecs[i].rr);
            check4($sformatf("vec%0d", i), vecs[i].e_wrdy, vecs[i].e_rvld,
                   fill(vecs[i].e_b), vecs[i].e_cnt);
         end

      // empty-write latency: no bypass in the cycle of the write
      wv4 = 1'b1; wd4 = fill(8'hA5); rr4 = 1'b0;
      @(negedge clk);
      check("lat pre rd_pvld", 512'(rvld4), 512'(1'b0));
      check("lat pre rd_pd", rd4, '0);
      @(posedge clk); #1;
      check4("lat post", 1'b1, 1'b1, fill(8'hA5), 1);

      // asynchronous reset at count=3
      d4_step(1'b1, fill(8'hB6), 1'b0);
      d4_step(1'b1, fill(8'hC7), 1'b0);
      check4("pre-areset", 1'b1, 1'b1, fill(8'hA5), 3);
      wv4 = 1'b0; rr4 = 1'b0;
      #2 rstn = 1'b0;
      #1 check4("areset", 1'b1, 1'b0, '0, 0);
      #2 rstn = 1'b1;
      d4_step(1'b0, '0, 1'b1);
      check4("post-areset", 1'b1, 1'b0, '0, 0);

      // DEPTH=5 streaming at count=2 wraps both pointers repeatedly
      q5.delete();
      d5_cycle("prime0", 1'b1, 32'h1000, 1'b0);
      d5_cycle("prime1", 1'b1, 32'h1001, 1'b0);
      for (int i = 0; i < 20; i++) begin
         d5_cycle($sformatf("stream%0d", i), 1'b1, 32'h2000 + 32'(i), 1'b1);
         if (cnt5 !== 3'd2) $display("FAIL stream%0d count got %0d expected 2", i, cnt5);
      end
      d5_cycle("flush0", 1'b0, 32'h0, 1'b1);
      d5_cycle("flush1", 1'b0, 32'h0, 1'b1);

      // randomized traffic; pending writes hold valid and data until accepted
      hold_v = 1'b0; hold_d = '0; last_acc5 = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!hold_v || last_acc5) begin
            hold_v = ($urandom_range(0, 99) < 60);
            hold_d = $urandom;
         end
         d5_cycle("rand", hold_v, hold_d, ($urandom_range(0, 99) < 45));
      end

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
